pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 49 ++++
 rtl/pc_ras.sv | 74 +++++++
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the PC sequencing logic.
//   - Instruction opcode constants used by the decode stage.
//   - Redirect kind encodings carried on redir_kind.
//   - Sequencer state encodings.
//   - A helper that maps a control-transfer opcode to its redirect kind.
package pc_pkg;

  // Primary opcode field values (instruction bits [31:26]).
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;

  // Function field values under OP_SPECIAL (instruction bits [5:0]).
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  // Redirect kinds; encodings 5..7 are reserved and mean "no redirect".
  typedef enum logic [2:0] {
    KIND_BEQ_TAKEN = 3'd0,
    KIND_JUMP      = 3'd1,
    KIND_JAL       = 3'd2,
    KIND_JR        = 3'd3,
    KIND_RET       = 3'd4
  } redir_kind_e;

  // Sequencer states.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } pc_state_e;

  // Redirect kind for a control-transfer instruction. A JR through the
  // link register is reported as RET so the return-address stack is used.
  function automatic redir_kind_e kind_from_opcode(input logic [5:0] opcode,
                                                   input logic [5:0] funct,
                                                   input logic       rs_is_link);
    redir_kind_e kind;
    kind = KIND_JUMP;
    case (opcode)
      OP_BEQ:     kind = KIND_BEQ_TAKEN;
      OP_J:       kind = KIND_JUMP;
      OP_JAL:     kind = KIND_JAL;
      OP_SPECIAL: if (funct == FUNCT_JR) kind = rs_is_link ? KIND_RET : KIND_JR;
      default:    kind = KIND_JUMP;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset; empties the stack
//   push       in   push push_data (overwrites the oldest entry when full)
//   pop        in   discard the top entry (ignored when empty)
//   push_data  in   DATA_W  value to push
//   top        out  DATA_W  current top entry (undefined when empty)
//   empty      out  no valid entries
//   full       out  DEPTH valid entries
// push and pop are never asserted together by the sequencer.
module pc_ras #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;   // next free slot; top is one below
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  top_idx;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign top_idx = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PTR_W'(1);
  assign top     = entries_q[top_idx];

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      // Wrapping the write pointer onto the oldest slot is what makes a push
      // on a full stack overwrite the oldest entry.
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      count_d  = full ? count_q : count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = top_idx;
      count_d  = count_q - CNT_W'(1);
    end
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block and
  // does not appear in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; count_q alone decides
  // which entries are valid, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) entries_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/jump redirects and a
// return-address stack.
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset (overrides everything)
//   stall        in   hold all state; a redirect presented while stalled is dropped
//   redir_valid  in   redirect requested this cycle
//   redir_kind   in   3       redirect kind (see pc_pkg::redir_kind_e)
//   br_offset    in   16      signed word offset for BEQ_TAKEN
//   j_index      in   26      word index for JUMP / JAL
//   jr_target    in   ADDR_W  JR target; RET fallback when the stack is empty
//   pc           out  ADDR_W  current PC (registered)
//   pc_plus4     out  ADDR_W  pc + 4 (combinational)
//   ras_empty    out  return-address stack empty
//   ras_full     out  return-address stack full
//   fault        out  sticky misaligned-indirect-target fault
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [2:0]        redir_kind,
  input  logic [15:0]       br_offset,
  input  logic [25:0]       j_index,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              fault
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [ADDR_W-1:0] br_disp;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] target;
  logic              indirect;
  logic              push_req, pop_req;
  logic              ras_push, ras_pop;

  // All adds are naturally modulo 2^ADDR_W.
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign br_disp  = {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};
  assign jump_tgt = {pc_plus4[ADDR_W-1:28], j_index, 2'b00};

  // Next-PC candidate and stack request for the presented redirect.
  always_comb begin
    target   = pc_plus4;
    indirect = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (redir_valid) begin
      case (redir_kind_e'(redir_kind))
        KIND_BEQ_TAKEN: target = pc_plus4 + br_disp;
        KIND_JUMP:      target = jump_tgt;
        KIND_JAL: begin
          target   = jump_tgt;
          push_req = 1'b1;
        end
        KIND_JR: begin
          target   = jr_target;
          indirect = 1'b1;
        end
        KIND_RET: begin
          target   = ras_empty ? jr_target : ras_top;
          indirect = 1'b1;
          pop_req  = !ras_empty;
        end
        default: ;  // reserved kinds advance sequentially
      endcase
    end
  end

  // State transition: a misaligned indirect target freezes everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (indirect && (target[1:0] != 2'b00)) begin
            state_d = ST_FAULT;
          end else begin
            pc_d     = target;
            ras_push = push_req;
            ras_pop  = pop_req;
          end
        end
      end
      ST_FAULT: ;  // hold until reset
      default:  state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  pc_ras #(
    .DATA_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc    = pc_q;
  assign fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (ADDR_W=32, RESET_VEC=0x400, RAS_DEPTH=4).
module tb_pc_sequencer;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              redir_valid;
  logic [2:0]        redir_kind;
  logic [15:0]       br_offset;
  logic [25:0]       j_index;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              ras_empty;
  logic              ras_full;
  logic              fault;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] K_BEQ = 3'd0, K_JUMP = 3'd1, K_JAL = 3'd2,
                         K_JR  = 3'd3, K_RET  = 3'd4, K_RSVD = 3'd5;

  pc_sequencer #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (32'h0000_0400),
    .RAS_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_kind  (redir_kind),
    .br_offset   (br_offset),
    .j_index     (j_index),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [2:0] kind);
    redir_valid = 1'b1;
    redir_kind  = kind;
    step();
    redir_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Links pushed by five JALs starting at pc=0x1004; see the JAL loop below.
  logic [31:0] links [5] = '{32'h0000_1008, 32'h0000_0404, 32'h0000_0504,
                             32'h0000_0604, 32'h0000_0704};

  initial begin
    reset = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_kind = '0;
    br_offset = '0; j_index = '0; jr_target = '0;

    // Reset state and free run.
    do_reset();
    check("reset_pc", pc, 32'h0000_0400);
    check("reset_pc_plus4", pc_plus4, 32'h0000_0404);
    check("reset_ras_empty", 32'(ras_empty), 32'd1);
    check("reset_ras_full", 32'(ras_full), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    repeat (3) step();
    check("free_run_3", pc, 32'h0000_040C);

    // BEQ with negative and maximum positive offsets.
    jr_target = 32'h0000_0100; redirect(K_JR);
    check("jr_0x100", pc, 32'h0000_0100);
    br_offset = 16'hFFFE; redirect(K_BEQ);
    check("beq_neg", pc, 32'h0000_00FC);
    jr_target = 32'h0; redirect(K_JR);
    br_offset = 16'h7FFF; redirect(K_BEQ);
    check("beq_max", pc, 32'h0002_0000);

    // JAL then RET.
    jr_target = 32'h0000_1000; redirect(K_JR);
    j_index = 26'h40; redirect(K_JAL);
    check("jal_pc", pc, 32'h0000_0100);
    check("jal_ras_nonempty", 32'(ras_empty), 32'd0);
    jr_target = 32'h0000_2000; redirect(K_RET);
    check("ret_pc", pc, 32'h0000_1004);
    check("ret_ras_empty", 32'(ras_empty), 32'd1);

    // Five JALs overflow the 4-entry stack; the oldest link is lost.
    for (int i = 0; i < 5; i++) begin
      j_index = 26'h100 + 26'(i * 26'h40);
      redirect(K_JAL);
      if (i == 3) check("ras_full_at_4", 32'(ras_full), 32'd1);
    end
    check("jal5_pc", pc, 32'h0000_0800);
    check("ras_full_at_5", 32'(ras_full), 32'd1);
    jr_target = 32'h0000_3000;
    for (int i = 4; i >= 1; i--) begin
      redirect(K_RET);
      check($sformatf("ret_link_%0d", i), pc, links[i]);
    end
    check("ras_empty_after_4", 32'(ras_empty), 32'd1);
    redirect(K_RET);
    check("ret5_fallback", pc, 32'h0000_3000);

    // Reserved kind advances sequentially.
    redirect(K_RSVD);
    check("reserved_seq", pc, 32'h0000_3004);

    // Stall drops a pending JAL.
    stall = 1'b1; j_index = 26'h10; redirect(K_JAL);
    check("stall_pc", pc, 32'h0000_3004);
    check("stall_ras", 32'(ras_empty), 32'd1);
    stall = 1'b0; step();
    check("after_stall_seq", pc, 32'h0000_3008);
    check("after_stall_ras", 32'(ras_empty), 32'd1);

    // JUMP keeps the upper nibble of pc+4.
    jr_target = 32'hF000_0000; redirect(K_JR);
    j_index = 26'h3FF_FFFF; redirect(K_JUMP);
    check("jump_upper", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    step();
    check("wrap_pc", pc, 32'h0000_0000);

    // Misaligned JR faults and freezes pc, RAS and fault.
    j_index = 26'h80; redirect(K_JAL);
    check("pre_fault_pc", pc, 32'h0000_0200);
    jr_target = 32'h0000_0202; redirect(K_JR);
    check("fault_set", 32'(fault), 32'd1);
    check("fault_pc_held", pc, 32'h0000_0200);
    for (int i = 0; i < 10; i++) begin
      jr_target = 32'h0000_0500;
      redirect((i % 3 == 0) ? K_JR : (i % 3 == 1) ? K_JAL : K_RET);
    end
    check("fault_pc_10", pc, 32'h0000_0200);
    check("fault_sticky", 32'(fault), 32'd1);
    check("fault_ras_held", 32'(ras_empty), 32'd0);

    // Reset overrides fault, stall and redirect together.
    stall = 1'b1; redir_valid = 1'b1; redir_kind = K_JR; reset = 1'b1;
    step();
    reset = 1'b0; redir_valid = 1'b0; stall = 1'b0;
    check("rst_fault_clr", 32'(fault), 32'd0);
    check("rst_pc", pc, 32'h0000_0400);
    check("rst_ras_empty", 32'(ras_empty), 32'd1);
    step();
    check("rst_run", pc, 32'h0000_0404);

    // RET on an empty stack with a misaligned fallback also faults.
    jr_target = 32'h0000_0003; redirect(K_RET);
    check("ret_fault", 32'(fault), 32'd1);
    check("ret_fault_pc", pc, 32'h0000_0404);
    do_reset();
    check("final_fault_clr", 32'(fault), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
